// File: rtl/result_display_pkg.sv
// Shared definitions for the result display: FSM state encoding, segment
// table, blanking constant, digit-select width and small helper functions.
package result_display_pkg;

  // Conversion controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Number of multiplexed digits and the width of the select that walks them.
  localparam int NUM_DIGITS  = 4;
  localparam int DIGIT_SEL_W = 2;

  // Binary input width and number of double-dabble shift cycles.
  localparam int BIN_W      = 8;
  localparam int BCD_W      = 12;
  localparam int SHIFT_CNT_W = 3;

  // Active-low segment patterns, bit0 = a ... bit6 = g.
  localparam logic [6:0] SSEG_BLANK = 7'b1111111;
  localparam logic [6:0] SSEG_TABLE [10] = '{
    7'b1000000,  // 0
    7'b1111001,  // 1
    7'b0100100,  // 2
    7'b0110000,  // 3
    7'b0011001,  // 4
    7'b0010010,  // 5
    7'b0000010,  // 6
    7'b1111000,  // 7
    7'b0000000,  // 8
    7'b0010000   // 9
  };

  // Double-dabble correction: a nibble of 5 or more would overflow past 9
  // when doubled, so bias it by 3 before the shift.
  function automatic logic [3:0] bcd_adjust(input logic [3:0] nib);
    return (nib >= 4'd5) ? (nib + 4'd3) : nib;
  endfunction

  // Active-low one-hot anode enable for a digit select value.
  function automatic logic [NUM_DIGITS-1:0] an_decode(input logic [DIGIT_SEL_W-1:0] sel);
    return ~(NUM_DIGITS'(1) << sel);
  endfunction

endpackage

// File: rtl/result_display_sseg_decoder.sv
// BCD digit to active-low seven-segment pattern, with a forced-blank input.
// Codes above 9 never occur in normal operation and are shown blank.
module sseg_decoder
  import result_display_pkg::*;
(
  input  logic [3:0] bcd_i,
  input  logic       blank_i,
  output logic [6:0] sseg_o
);

  // Table lookup unless the digit is blanked or out of range.
  always_comb begin
    sseg_o = SSEG_BLANK;
    if (!blank_i && (bcd_i <= 4'd9)) begin
      sseg_o = SSEG_TABLE[bcd_i];
    end
  end

endmodule

// File: rtl/result_display.sv
// Converts an 8-bit unsigned result to BCD with a serial double-dabble
// engine and shows it on a 4-digit multiplexed seven-segment display.
// The shown digits only update when a conversion completes, so the old
// value stays visible while a new one is being converted.
module result_display
  import result_display_pkg::*;
#(
  parameter int REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init,
  input  logic [BIN_W-1:0]      value,
  output logic [6:0]            sseg,
  output logic [NUM_DIGITS-1:0] an,
  output logic                  busy,
  output logic                  done
);

  localparam int CNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);

  // ---------------------------------------------------------------------
  // Conversion state
  // ---------------------------------------------------------------------
  state_t                 state_q, state_d;
  logic [BIN_W-1:0]       bin_q, bin_d;
  logic [BCD_W-1:0]       bcd_q, bcd_d;
  logic [SHIFT_CNT_W-1:0] shcnt_q, shcnt_d;

  // Committed display digits
  logic [3:0] hund_q, hund_d;
  logic [3:0] tens_q, tens_d;
  logic [3:0] units_q, units_d;

  // One double-dabble step computed from the current scratch
  logic [BCD_W-1:0] bcd_adj;
  logic [BCD_W-1:0] bcd_shift;
  logic [BIN_W-1:0] bin_shift;

  // Refresh / multiplex state
  logic [CNT_W-1:0]       refresh_q, refresh_d;
  logic [DIGIT_SEL_W-1:0] sel_q, sel_d;

  // Registered display outputs
  logic [6:0]            sseg_q, sseg_d;
  logic [NUM_DIGITS-1:0] an_q, an_d;

  // Digit routed to the shared decoder for the next refresh slot
  logic [3:0] dec_bcd;
  logic       dec_blank;

  // Correct each nibble, then shift the combined {bcd, bin} left by one.
  always_comb begin
    bcd_adj = {bcd_adjust(bcd_q[11:8]), bcd_adjust(bcd_q[7:4]), bcd_adjust(bcd_q[3:0])};
    {bcd_shift, bin_shift} = {bcd_adj, bin_q} << 1;
  end

  // Next-state logic of the conversion FSM and the display digit commit.
  always_comb begin
    state_d = state_q;
    bin_d   = bin_q;
    bcd_d   = bcd_q;
    shcnt_d = shcnt_q;
    hund_d  = hund_q;
    tens_d  = tens_q;
    units_d = units_q;
    unique case (state_q)
      ST_IDLE: begin
        if (init) begin
          bin_d   = value;
          bcd_d   = '0;
          shcnt_d = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        bin_d   = bin_shift;
        bcd_d   = bcd_shift;
        shcnt_d = shcnt_q + 1'b1;
        // The eighth shift completes the conversion; commit its result
        // directly so the digits are valid while done is high.
        if (shcnt_q == SHIFT_CNT_W'(BIN_W - 1)) begin
          state_d = ST_DONE;
          hund_d  = bcd_shift[11:8];
          tens_d  = bcd_shift[7:4];
          units_d = bcd_shift[3:0];
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Status outputs decode straight from the state register.
  always_comb begin
    busy = (state_q != ST_IDLE);
    done = (state_q == ST_DONE);
  end

  // Conversion and display-digit registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      shcnt_q <= '0;
      hund_q  <= '0;
      tens_q  <= '0;
      units_q <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      shcnt_q <= shcnt_d;
      hund_q  <= hund_d;
      tens_q  <= tens_d;
      units_q <= units_d;
    end
  end

  // Refresh counter wraps every REFRESH_DIV cycles and steps the digit select.
  always_comb begin
    refresh_d = refresh_q + 1'b1;
    sel_d     = sel_q;
    if (refresh_q == CNT_LAST) begin
      refresh_d = '0;
      sel_d     = sel_q + 1'b1;
    end
  end

  // Refresh counter and digit select registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      refresh_q <= '0;
      sel_q     <= '0;
    end else begin
      refresh_q <= refresh_d;
      sel_q     <= sel_d;
    end
  end

  // Pick the digit and leading-zero blanking for the slot being entered.
  always_comb begin
    dec_bcd   = units_q;
    dec_blank = 1'b0;
    unique case (sel_d)
      2'd0: begin
        dec_bcd   = units_q;
        dec_blank = 1'b0;
      end
      2'd1: begin
        dec_bcd   = tens_q;
        dec_blank = (hund_q == 4'd0) && (tens_q == 4'd0);
      end
      2'd2: begin
        dec_bcd   = hund_q;
        dec_blank = (hund_q == 4'd0);
      end
      default: begin
        dec_bcd   = 4'd0;
        dec_blank = 1'b1;
      end
    endcase
  end

  sseg_decoder u_sseg_decoder (
    .bcd_i   (dec_bcd),
    .blank_i (dec_blank),
    .sseg_o  (sseg_d)
  );

  // Anode enable for the slot being entered.
  always_comb begin
    an_d = an_decode(sel_d);
  end

  // Segment and anode outputs registered together so they switch on one edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sseg_q <= SSEG_TABLE[0];
      an_q   <= an_decode('0);
    end else begin
      sseg_q <= sseg_d;
      an_q   <= an_d;
    end
  end

  assign sseg = sseg_q;
  assign an   = an_q;

endmodule

// File: tb/tb_result_display.sv
// Self-checking bench for result_display with a fast refresh divider.
module tb_result_display;

  localparam int DIV = 4;

  logic       clk;
  logic       rst_n;
  logic       init;
  logic [7:0] value;
  logic [6:0] sseg;
  logic [3:0] an;
  logic       busy;
  logic       done;

  int n_cmp;
  int n_bad;

  logic [6:0] seg_ref [10];

  result_display #(.REFRESH_DIV(DIV)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .init  (init),
    .value (value),
    .sseg  (sseg),
    .an    (an),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected pattern for display position d when v is shown.
  function automatic logic [6:0] exp_seg(input int v, input int d);
    int h, t, u;
    h = v / 100;
    t = (v / 10) % 10;
    u = v % 10;
    case (d)
      0: return seg_ref[u];
      1: return (v < 10) ? 7'b1111111 : seg_ref[t];
      2: return (v < 100) ? 7'b1111111 : seg_ref[h];
      default: return 7'b1111111;
    endcase
  endfunction

  // Pulse init with v and measure the edge on which done shows up.
  task automatic do_conversion(input logic [7:0] v, input string tag);
    int cycles;
    bit seen;
    @(negedge clk);
    init  = 1'b1;
    value = v;
    @(posedge clk);
    #1;
    init = 1'b0;
    cycles = 1;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy_start: got %b want 1", tag, busy);
    end
    seen = 1'b0;
    while (cycles < 20 && !seen) begin
      if (done === 1'b1) seen = 1'b1;
      else begin
        @(posedge clk);
        #1;
        cycles++;
      end
    end
    n_cmp++;
    if (!seen || cycles != 9) begin
      n_bad++;
      $display("FAIL %s latency: got %0d (seen=%0b) want 9", tag, cycles, seen);
    end
    @(posedge clk);
    #1;
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s done_width: got done=%b busy=%b want 0/0", tag, done, busy);
    end
    $display("conv %s value=%0d latency=%0d", tag, v, cycles);
  endtask

  // Visit all four positions and compare the segments against the model.
  task automatic check_display(input int v, input string tag);
    logic [3:0] want_an;
    int wait_c;
    @(posedge clk);
    #1;
    for (int d = 0; d < 4; d++) begin
      want_an = ~(4'b0001 << d);
      wait_c = 0;
      while (an !== want_an && wait_c < 20) begin
        @(posedge clk);
        #1;
        wait_c++;
      end
      n_cmp++;
      if (an !== want_an) begin
        n_bad++;
        $display("FAIL %s an_timeout digit%0d: got %b want %b", tag, d, an, want_an);
      end else if (sseg !== exp_seg(v, d)) begin
        n_bad++;
        $display("FAIL %s sseg digit%0d: got %b want %b", tag, d, sseg, exp_seg(v, d));
      end
    end
    $display("disp %s value=%0d checked", tag, v);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    init  = 1'b0;
    value = 8'd0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (an !== 4'b1110 || sseg !== 7'b1000000 || busy !== 1'b0 || done !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_state: got an=%b sseg=%b busy=%b done=%b want 1110 1000000 0 0",
               an, sseg, busy, done);
    end
    $display("reset applied");
  endtask

  // Must run directly after test_reset: n counts edges since the last reset edge.
  task automatic test_refresh();
    logic [3:0] want_an;
    for (int n = 1; n <= 20; n++) begin
      @(posedge clk);
      #1;
      want_an = ~(4'b0001 << ((n / DIV) % 4));
      n_cmp++;
      if (an !== want_an) begin
        n_bad++;
        $display("FAIL refresh n=%0d: got %b want %b", n, an, want_an);
      end
    end
    $display("refresh sequence checked over 20 cycles");
  endtask

  task automatic test_known();
    do_conversion(8'd173, "v173");
    check_display(173, "v173");
    do_conversion(8'd0, "v0");
    check_display(0, "v0");
    do_conversion(8'd5, "v5");
    check_display(5, "v5");
    do_conversion(8'd255, "v255");
    check_display(255, "v255");
  endtask

  task automatic test_back_to_back();
    int dones;
    @(negedge clk);
    init  = 1'b1;
    value = 8'd173;
    @(posedge clk);
    #1;
    init  = 1'b0;
    dones = 0;
    for (int c = 1; c <= 20; c++) begin
      if (c == 3) begin
        init  = 1'b1;
        value = 8'd42;
      end
      if (c == 4) init = 1'b0;
      if (done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    init = 1'b0;
    n_cmp++;
    if (dones != 1) begin
      n_bad++;
      $display("FAIL b2b done_count: got %0d want 1", dones);
    end
    $display("b2b 173 then 42 dones=%0d", dones);
    check_display(173, "b2b");
  endtask

  task automatic test_reset_mid();
    int dones;
    @(negedge clk);
    init  = 1'b1;
    value = 8'd200;
    @(posedge clk);
    #1;
    init  = 1'b0;
    dones = 0;
    for (int c = 1; c < 4; c++) begin
      if (done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    n_cmp++;
    if (busy !== 1'b0 || an !== 4'b1110 || sseg !== 7'b1000000) begin
      n_bad++;
      $display("FAIL reset_mid state: got busy=%b an=%b sseg=%b want 0 1110 1000000", busy, an, sseg);
    end
    for (int c = 0; c < 12; c++) begin
      if (done === 1'b1) dones++;
      @(posedge clk);
      #1;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL reset_mid done_count: got %0d want 0", dones);
    end
    $display("reset_mid aborted conversion dones=%0d", dones);
    check_display(0, "reset_mid");
  endtask

  task automatic test_random();
    logic [7:0] v;
    for (int i = 0; i < 12; i++) begin
      v = 8'($urandom_range(0, 255));
      do_conversion(v, "rand");
      check_display(int'(v), "rand");
    end
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    seg_ref[0] = 7'b1000000;
    seg_ref[1] = 7'b1111001;
    seg_ref[2] = 7'b0100100;
    seg_ref[3] = 7'b0110000;
    seg_ref[4] = 7'b0011001;
    seg_ref[5] = 7'b0010010;
    seg_ref[6] = 7'b0000010;
    seg_ref[7] = 7'b1111000;
    seg_ref[8] = 7'b0000000;
    seg_ref[9] = 7'b0010000;
    test_reset();
    test_refresh();
    test_known();
    test_back_to_back();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/result_display.md
RESULT_DISPLAY -- requirements
Module: result_display

Interface
REQ-001 The module SHALL have parameter REFRESH_DIV, default 50000, giving the clock cycles each digit stays enabled; legal range 2..2^20.
REQ-002 The module SHALL have port clk, input, 1, the single clock; all logic on rising edge.
REQ-003 The module SHALL have port rst_n, input, 1, with reset synchronous and active-low.
REQ-004 The module SHALL have port init, input, 1, a start request that latches value when the block is idle.
REQ-005 The module SHALL have port value, input, 8, the unsigned arithmetic-stage result (0..255) to display.
REQ-006 The module SHALL have port sseg, output, 7, active-low segments: bit0=a through bit6=g.
REQ-007 The module SHALL have port an, output, 4, active-low one-hot digit enables: an[0]=units … an[3]=leftmost.
REQ-008 The module SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-009 The module SHALL have port done, output, 1, a one-cycle pulse when new digits are committed.

Function
REQ-010 The FSM SHALL have states IDLE, SHIFT, DONE, moving IDLE->SHIFT on init=1, SHIFT->DONE after 8 shift cycles, and DONE->IDLE unconditionally.
REQ-011 In IDLE with init=1 at edge k, value SHALL be captured into an 8-bit shift register, the 12-bit BCD scratch cleared, and the 3-bit shift count zeroed.
REQ-012 Each SHIFT cycle SHALL first add 3 to each BCD nibble >=5, then shift {bcd,bin} left by one (double-dabble).
REQ-013 After edge k+8 the state SHALL be DONE, the hundreds/tens/units display registers SHALL load from the scratch, and done SHALL be 1 for exactly that cycle.
REQ-014 Latency from init sample to done SHALL be exactly 9 clocks.
REQ-015 busy SHALL be 1 in SHIFT and DONE and 0 in IDLE.
REQ-016 init asserted while busy=1 SHALL be ignored, and a new value SHALL be captured only at an IDLE edge.
REQ-017 Display registers SHALL change only on DONE, so the old digits remain shown throughout a conversion.
REQ-018 A refresh counter SHALL count 0..REFRESH_DIV-1 and wrap; on wrap, the 2-bit digit select SHALL advance 0->1->2->3->0.
REQ-019 an SHALL be the active-low one-hot decode of digit select, with exactly one bit low at all times.
REQ-020 Digit 3 SHALL always be blank (sseg=1111111).
REQ-021 The hundreds digit SHALL be blank when it is 0, and the tens digit SHALL be blank when both hundreds and tens are 0.
REQ-022 The units digit SHALL always be shown.
REQ-023 Segment codes for '0' through '9' SHALL be 1000000, 1111001, 0100100, 0110000, 0011001, 0010010, 0000010, 1111000, 0000000, 0010000.
REQ-024 sseg SHALL be registered, changing on the same edge as an.

Reset
REQ-025 While rst_n=0 at a clock edge, the block SHALL set state=IDLE, busy=0, done=0, the shift count to 0, the refresh counter to 0, digit select to 0, and all display digits to 0.
REQ-026 After reset the outputs SHALL be an=1110 and sseg=1000000 (units shows '0').
REQ-027 Reset during SHIFT or DONE SHALL abort the conversion, with no done pulse and digits cleared to 0.

Structure
REQ-028 A shared package SHALL hold the state encoding, the 10-entry segment table, the SSEG_BLANK constant, and the digit-select width.
REQ-029 The design SHALL contain one combinational sub-module, sseg_decoder (4-bit BCD plus blank flag in, 7-bit active-low segments out).
REQ-030 The refresh counter width SHALL be derived from REFRESH_DIV using $clog2.

Verification
REQ-031 value=173 with an init pulse -> done at +9 clocks, with hundreds=1, tens=7, units=3 and sseg codes 1111001, 1111000, 0110000.
REQ-032 value=0, then value=5 -> units shows 1000000, then 0010010, with an[1] and an[2] showing 1111111 (blanking).
REQ-033 value=255 -> digits 2, 5, 5, with sseg 0100100, 0010010, 0010010.
REQ-034 value=173 followed by a second init with value=42 at +3 clocks -> the second init is ignored, exactly one done pulse occurs, and 1, 7, 3 is displayed.
REQ-035 rst_n=0 at +4 clocks into a conversion -> no done pulse, busy=0, an=1110, sseg=1000000.
REQ-036 REFRESH_DIV=4 -> an cycles 1110, 1101, 1011, 0111, each held 4 clocks, and wraps after 16 clocks.
